dual_adc_capture: RTL

//  Receive-side counterpart of the dual 8-bit parallel DAC path: clocks two 8-bit parallel ADCs from clk,

---
 rtl/dual_adc_pkg.sv | 15 +
 rtl/sample_fifo.sv | 71 +++++++
 rtl/dual_adc_capture.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/dual_adc_pkg.sv
// Shared types and widths for the dual ADC capture path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dual_adc_pkg;

    localparam int ADC_W    = 8;
    localparam int SAMPLE_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous first-word-fall-through FIFO for captured sample pairs.
// Latency: write to not-empty 1 cycle; head word is visible combinationally from storage.
// Backpressure: writes while full are dropped unless a pop happens in the same cycle.
//
// Ports:
//   clk, rst_n        clock, async active-low reset (flushes pointers and count)
//   wr_en, wr_data    push request and word
//   rd_en             pop request, ignored while empty
//   rd_data           head word, forced to 0 while empty
//   full, empty       occupancy flags
module sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

    // A pop in the same cycle frees the slot, so a write when full still lands.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    // Gate the head so the stream reads 0 while nothing is stored.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dual_adc_capture.sv
// Dual 8-bit ADC capture: register, decimate, arm/trigger on channel A, stream {B,A} pairs.
// Latency: ADC pin to FIFO write 2 cycles; FIFO write to out_valid 1 cycle.
// Backpressure: out_valid/out_ready stream from a FWFT FIFO; writes into a full FIFO are dropped and flagged.
//
// Ports:
//   clk, nReset              system clock, async active-low reset
//   adc_a_c, adc_b_c         ADC sample clocks (copies of clk)
//   adc_a_d, adc_b_d         ADC data, offset binary
//   arm, force_trig          start a capture / trigger immediately while armed
//   trig_rise, trig_level    trigger polarity and threshold on channel A
//   out_data/valid/ready     {B,A} sample-pair stream
//   busy, done, overflow     status: capture in progress, last-sample pulse, sticky drop flag
//
// Build option: define DUAL_ADC_TEST_PATTERN_EN to replace the ADC pins with an internal ramp
// (A = ramp, B = ~ramp) for loopback without ADCs.
module dual_adc_capture
    import dual_adc_pkg::*;
#(
    parameter int DECIM       = 1,
    parameter int CAPTURE_LEN = 256,
    parameter int FIFO_DEPTH  = 64
) (
    input  logic                clk,
    input  logic                nReset,
    output logic                adc_a_c,
    output logic                adc_b_c,
    input  logic [ADC_W-1:0]    adc_a_d,
    input  logic [ADC_W-1:0]    adc_b_d,
    input  logic                arm,
    input  logic                force_trig,
    input  logic                trig_rise,
    input  logic [ADC_W-1:0]    trig_level,
    output logic [SAMPLE_W-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                done,
    output logic                overflow
);

    localparam int DCNT_W = $clog2(DECIM) + 1;
    localparam logic [DCNT_W-1:0] DCNT_MAX = DCNT_W'(DECIM - 1);
    localparam int CNT_W = $clog2(CAPTURE_LEN + 1);
    localparam logic [CNT_W-1:0] LEN_C = CNT_W'(CAPTURE_LEN);

    state_t            state;
    logic [ADC_W-1:0]  src_a;
    logic [ADC_W-1:0]  src_b;
    logic [ADC_W-1:0]  s1_a;
    logic [ADC_W-1:0]  s1_b;
    logic [ADC_W-1:0]  s2_a;
    logic [ADC_W-1:0]  s2_b;
    logic [ADC_W-1:0]  prev_a;
    logic              prev_vld;
    logic [DCNT_W-1:0] dcnt;
    logic              strobe;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nxt;
    logic              rise_hit;
    logic              fall_hit;
    logic              trig_hit;
    logic              wr_en;
    logic              fifo_full;
    logic              fifo_empty;

    assign adc_a_c = clk;
    assign adc_b_c = clk;

`ifdef DUAL_ADC_TEST_PATTERN_EN
    logic [ADC_W-1:0] ramp;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            ramp <= '0;
        end else begin
            ramp <= ramp + 1'b1;
        end
    end

    assign src_a = ramp;
    assign src_b = ~ramp;
`else
    assign src_a = adc_a_d;
    assign src_b = adc_b_d;
`endif

    // Stage 1 captures the pins, stage 2 is the "current" sample used by trigger and FIFO.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            s1_a <= '0;
            s1_b <= '0;
            s2_a <= '0;
            s2_b <= '0;
        end else begin
            s1_a <= src_a;
            s1_b <= src_b;
            s2_a <= s1_a;
            s2_b <= s1_b;
        end
    end

    // Free-running decimator; strobe on the zero phase.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            dcnt <= '0;
        end else if (dcnt == DCNT_MAX) begin
            dcnt <= '0;
        end else begin
            dcnt <= dcnt + 1'b1;
        end
    end

    assign strobe = (dcnt == '0);

    assign rise_hit  = (prev_a < trig_level) && (s2_a >= trig_level);
    assign fall_hit  = (prev_a > trig_level) && (s2_a <= trig_level);
    assign trig_hit  = force_trig || (prev_vld && (trig_rise ? rise_hit : fall_hit));
    assign count_nxt = count + 1'b1;

    assign wr_en = strobe && (((state == ARMED) && trig_hit) || (state == CAPTURE));

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state    <= IDLE;
            count    <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
            overflow <= 1'b0;
            prev_a   <= '0;
            prev_vld <= 1'b0;
        end else begin
            done <= 1'b0;

            if (strobe) begin
                prev_a   <= s2_a;
                prev_vld <= 1'b1;
            end

            // The sample counter still advances on a drop so capture length stays fixed.
            if (wr_en && fifo_full && !out_ready) begin
                overflow <= 1'b1;
            end

            case (state)
                IDLE: begin
                    // An arm coinciding with the done pulse is discarded.
                    busy <= arm && !done;
                    if (arm && !done) begin
                        state    <= ARMED;
                        overflow <= 1'b0;
                        count    <= '0;
                        prev_vld <= 1'b0;
                    end
                end
                ARMED: begin
                    busy <= 1'b1;
                    if (wr_en) begin
                        count <= CNT_W'(1);
                        if (LEN_C == CNT_W'(1)) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            state <= CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
                    // busy stays high through the done cycle and drops after it.
                    busy <= 1'b1;
                    if (wr_en) begin
                        count <= count_nxt;
                        if (count_nxt == LEN_C) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    sample_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (nReset),
        .wr_en   (wr_en),
        .wr_data ({s2_b, s2_a}),
        .rd_en   (out_ready),
        .rd_data (out_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign out_valid = !fifo_empty;

endmodule
